// File: rtl/ether_export_sched_if.sv
// ---------------------------------------------------------------------------
// ether_export_sched_if
// Purpose : bundles the renderer/exporter handshake of the frame export
//           scheduler so the scheduler and its driver share one port.
// Signals :
//   mode_in            [1:0] 0=off, 1=single-shot, 2/3=continuous
//   start_in                 one-cycle arm pulse
//   frame_done_in            renderer finished a frame
//   export_ready_in          exporter idle / able to accept a trigger
//   export_trigger_out       one-cycle trigger to the exporter
//   hold_render_out          freeze renderer buffer writes
//   busy_out                 scheduler not idle
//   frame_count_out   [15:0] completed exports (wrapping)
//   timeout_out              sticky abort flag
// Modports: master drives the inputs, slave is the scheduler itself.
// ---------------------------------------------------------------------------
interface ether_export_sched_if;
    logic [1:0]  mode_in;
    logic        start_in;
    logic        frame_done_in;
    logic        export_ready_in;
    logic        export_trigger_out;
    logic        hold_render_out;
    logic        busy_out;
    logic [15:0] frame_count_out;
    logic        timeout_out;

    modport master (
        output mode_in, start_in, frame_done_in, export_ready_in,
        input  export_trigger_out, hold_render_out, busy_out,
               frame_count_out, timeout_out
    );

    modport slave (
        input  mode_in, start_in, frame_done_in, export_ready_in,
        output export_trigger_out, hold_render_out, busy_out,
               frame_count_out, timeout_out
    );
endinterface

// File: rtl/ether_export_sched.sv
// ---------------------------------------------------------------------------
// ether_export_sched
// Purpose : schedules exports of rendered frames. After arming it waits for
//           a finished frame, waits for the exporter, fires a one-cycle
//           trigger, holds the renderer while the exporter works, then
//           enforces an idle gap before the next export (continuous mode)
//           or returns to idle (single-shot). A watchdog aborts a stuck
//           export and raises a sticky timeout flag.
// Ports   :
//   clk_in    rising-edge system clock
//   rst_n_in  asynchronous active-low reset
//   bus       ether_export_sched_if.slave handshake bundle
// All outputs are registered copies of the next-state decode (Moore).
// ---------------------------------------------------------------------------
module ether_export_sched #(
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    ether_export_sched_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_WAIT_READY = 3'd2,
        S_TRIG       = 3'd3,
        S_EXPORTING  = 3'd4,
        S_GAP        = 3'd5
    } state_t;

    localparam int unsigned     TMO_W    = 25;
    localparam int unsigned     GAP_W    = 20;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_seen_low;
    logic [15:0]        r_frame_count;
    logic               r_timeout;
    logic               r_trig;
    logic               r_hold;
    logic               r_busy;
    logic               w_tmo_hit;
    logic               w_done;
    logic               w_set_timeout;

    // Watchdog expires on the TIMEOUT_CYCLES-th cycle since WAIT_READY entry.
    assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);

    // Next-state decode; timeout outranks both abort and completion.
    always_comb begin
        w_next_state  = r_state;
        w_done        = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_in && (bus.mode_in != 2'd0)) begin
                    w_next_state = S_WAIT_FRAME;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_FRAME: begin
                if (bus.mode_in == 2'd0) begin
                    w_next_state = S_IDLE;
                end else if (bus.frame_done_in) begin
                    w_next_state = S_WAIT_READY;
                end else begin
                    w_next_state = S_WAIT_FRAME;
                end
            end
            S_WAIT_READY: begin
                if (w_tmo_hit) begin
                    w_next_state  = S_IDLE;
                    w_set_timeout = 1'b1;
                end else if (bus.mode_in == 2'd0) begin
                    w_next_state = S_IDLE;
                end else if (bus.export_ready_in) begin
                    w_next_state = S_TRIG;
                end else begin
                    w_next_state = S_WAIT_READY;
                end
            end
            S_TRIG: begin
                w_next_state = S_EXPORTING;
            end
            S_EXPORTING: begin
                // Completion needs a ready low->high sequence, so the ready
                // level left over from before the trigger cannot finish it.
                if (w_tmo_hit) begin
                    w_next_state  = S_IDLE;
                    w_set_timeout = 1'b1;
                end else if (bus.export_ready_in && r_seen_low) begin
                    w_next_state = S_GAP;
                    w_done       = 1'b1;
                end else begin
                    w_next_state = S_EXPORTING;
                end
            end
            S_GAP: begin
                // Mode is sampled only here, so mid-export mode changes
                // only decide where the gap goes.
                if (r_gap_cnt == {GAP_W{1'b0}}) begin
                    if (bus.mode_in >= 2'd2) begin
                        w_next_state = S_WAIT_FRAME;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_GAP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Watchdog counter: cleared on WAIT_READY entry, runs through the export.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if ((r_state != S_WAIT_READY) && (w_next_state == S_WAIT_READY)) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (((r_state == S_WAIT_READY) || (r_state == S_TRIG) ||
                      (r_state == S_EXPORTING)) && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    // Gap down-counter: loaded on GAP entry, exits the cycle it reads zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gap_cnt <= {GAP_W{1'b0}};
        end else if ((r_state != S_GAP) && (w_next_state == S_GAP)) begin
            r_gap_cnt <= GAP_LOAD;
        end else if ((r_state == S_GAP) && (r_gap_cnt != {GAP_W{1'b0}})) begin
            r_gap_cnt <= r_gap_cnt - {{(GAP_W-1){1'b0}}, 1'b1};
        end
    end

    // Records that the exporter went busy after our trigger.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_seen_low <= 1'b0;
        end else if (r_state == S_TRIG) begin
            r_seen_low <= 1'b0;
        end else if ((r_state == S_EXPORTING) && !bus.export_ready_in) begin
            r_seen_low <= 1'b1;
        end
    end

    // Completed-export counter (natural 16-bit wrap) and sticky timeout flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_frame_count <= 16'd0;
            r_timeout     <= 1'b0;
        end else begin
            if (w_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if ((r_state == S_IDLE) && (w_next_state == S_WAIT_FRAME)) begin
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Registered Moore outputs decoded from the next state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_trig <= 1'b0;
            r_hold <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_trig <= (w_next_state == S_TRIG);
            r_hold <= (w_next_state == S_WAIT_READY) || (w_next_state == S_TRIG) ||
                      (w_next_state == S_EXPORTING);
            r_busy <= (w_next_state != S_IDLE);
        end
    end

    assign bus.export_trigger_out = r_trig;
    assign bus.hold_render_out    = r_hold;
    assign bus.busy_out           = r_busy;
    assign bus.frame_count_out    = r_frame_count;
    assign bus.timeout_out        = r_timeout;

endmodule
